// File: rtl/proc_control.sv
// proc_control: multi-cycle fetch/decode/exec/writeback sequencer
// feeding the register array and ALU from 16-bit instruction words.
module proc_control #(
   parameter int PC_W   = 8,
   parameter int REG_AW = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_data,
   input  logic              imem_valid,
   output logic              en,
   output logic              we,
   output logic [REG_AW-1:0] sela,
   output logic [REG_AW-1:0] selb,
   output logic [DATA_W-1:0] write,
   output logic [3:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [2:0]        alu_flags,
   output logic [PC_W-1:0]   pc,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [2:0]        fcap_q, fcap_d;
   logic [2:0]        flags_q, flags_d;

   logic [3:0]        op;
   logic [5:0]        ra;
   logic [5:0]        rb;
   logic              is_alu;
   logic              is_ldi;
   logic              is_bz;
   logic              is_jmp;
   logic              is_nop;
   logic              is_halt;
   logic [PC_W-1:0]   off;
   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   pc_br;
   logic [DATA_W-1:0] ldi_val;

   // only the zero flag steers control flow today
   logic              unused_flags;

   assign op      = ir_q[15:12];
   assign ra      = ir_q[11:6];
   assign rb      = ir_q[5:0];
   assign is_alu  = (op <= 4'h9);
   assign is_ldi  = (op == 4'hA);
   assign is_bz   = (op == 4'hB);
   assign is_jmp  = (op == 4'hC);
   assign is_nop  = (op == 4'hD) || (op == 4'hE);
   assign is_halt = (op == 4'hF);

   assign off     = {{(PC_W-6){rb[5]}}, rb};
   assign pc_inc  = pc_q + PC_W'(1);
   assign pc_br   = pc_q + off;
   assign ldi_val = {{(DATA_W-6){1'b0}}, rb};

   assign unused_flags = ^flags_q[2:1];

   assign imem_addr = pc_q;
   assign pc        = pc_q;

   // state, pc and datapath capture registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         res_q   <= '0;
         fcap_q  <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         res_q   <= res_d;
         fcap_q  <= fcap_d;
         flags_q <= flags_d;
      end
   end

   // next-state sequencing and pc update
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      res_d   = res_q;
      fcap_d  = fcap_q;
      flags_d = flags_q;
      unique case (state_q)
         S_FETCH: begin
            if (imem_valid) begin
               ir_d    = imem_data;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (1'b1)
               is_alu:  state_d = S_EXEC;
               is_ldi:  state_d = S_WB;
               is_bz: begin
                  pc_d    = flags_q[0] ? pc_br : pc_inc;
                  state_d = S_FETCH;
               end
               is_jmp: begin
                  pc_d    = pc_br;
                  state_d = S_FETCH;
               end
               is_nop: begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
               is_halt: state_d = S_HALT;
               default: state_d = S_FETCH;
            endcase
         end
         S_EXEC: begin
            res_d   = alu_out;
            fcap_d  = alu_flags;
            state_d = S_WB;
         end
         S_WB: begin
            if (is_alu) begin
               flags_d = fcap_q;
            end
            pc_d    = pc_inc;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // strobes and selects; all quiet while rst is held
   always_comb begin
      imem_req = 1'b0;
      en       = 1'b0;
      we       = 1'b0;
      sela     = '0;
      selb     = '0;
      write    = '0;
      alu_sel  = '0;
      halted   = 1'b0;
      if (!rst) begin
         unique case (state_q)
            S_FETCH: imem_req = 1'b1;
            S_DECODE: begin
               sela = REG_AW'(ra);
               selb = REG_AW'(rb);
               if (is_alu) begin
                  en      = 1'b1;
                  alu_sel = op;
               end
            end
            S_EXEC: begin
               en      = 1'b1;
               sela    = REG_AW'(ra);
               selb    = REG_AW'(rb);
               alu_sel = op;
            end
            S_WB: begin
               en    = 1'b1;
               we    = 1'b1;
               sela  = REG_AW'(ra);
               write = is_alu ? res_q : ldi_val;
            end
            S_HALT:  halted = 1'b1;
            default: imem_req = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: directed scenario bench for proc_control
// inputs change and outputs are sampled on the falling edge
module tb_proc_control;

   localparam int PC_W   = 8;
   localparam int REG_AW = 6;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic [15:0]       imem_data = '0;
   logic              imem_valid = 1'b0;
   logic              en;
   logic              we;
   logic [REG_AW-1:0] sela;
   logic [REG_AW-1:0] selb;
   logic [DATA_W-1:0] write;
   logic [3:0]        alu_sel;
   logic [DATA_W-1:0] alu_out = '0;
   logic [2:0]        alu_flags = '0;
   logic [PC_W-1:0]   pc;
   logic              halted;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   proc_control #(
      .PC_W   (PC_W),
      .REG_AW (REG_AW),
      .DATA_W (DATA_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .imem_valid (imem_valid),
      .en         (en),
      .we         (we),
      .sela       (sela),
      .selb       (selb),
      .write      (write),
      .alu_sel    (alu_sel),
      .alu_out    (alu_out),
      .alu_flags  (alu_flags),
      .pc         (pc),
      .halted     (halted)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // called in FETCH; returns on the falling edge in DECODE
   task automatic do_fetch(input logic [15:0] instr, input int waits);
      imem_valid = 1'b0;
      repeat (waits) step();
      imem_data  = instr;
      imem_valid = 1'b1;
      step();
      imem_valid = 1'b0;
   endtask

   task automatic run_alu(input logic [15:0] instr,
                          input logic [7:0] res,
                          input logic [2:0] fl);
      do_fetch(instr, 0);
      step();
      alu_out   = res;
      alu_flags = fl;
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      imem_valid = 1'b0;
      step();
      step();
      checks++;
      if ({imem_req, en, we, halted} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_strobes: got %b exp 0000",
                  {imem_req, en, we, halted});
      end
      checks++;
      if (pc !== 8'h00) begin
         errors++;
         $display("FAIL rst_pc: got %h exp 00", pc);
      end
      checks++;
      if ({sela, selb, write, alu_sel} !== 24'h0) begin
         errors++;
         $display("FAIL rst_sel: got %h exp 0",
                  {sela, selb, write, alu_sel});
      end
   endtask

   task automatic test_ldi();
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            imem_data  = 16'hA045;
            imem_valid = 1'b1;
         end
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL ldi_req%0d: got %b/%h exp 1/00",
                     i, imem_req, imem_addr);
         end
         step();
      end
      imem_valid = 1'b0;
      checks++;
      if (imem_req !== 1'b0 || sela !== 6'd1 || selb !== 6'd5) begin
         errors++;
         $display("FAIL ldi_dec: got req=%b a=%0d b=%0d exp 0/1/5",
                  imem_req, sela, selb);
      end
      step();
      checks++;
      if (we !== 1'b1 || en !== 1'b1 || sela !== 6'd1
          || write !== 8'h05) begin
         errors++;
         $display("FAIL ldi_wb: got we=%b en=%b a=%0d w=%h exp 1/1/1/05",
                  we, en, sela, write);
      end
      step();
      checks++;
      if (pc !== 8'h01 || we !== 1'b0 || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL ldi_pc: got pc=%h we=%b req=%b exp 01/0/1",
                  pc, we, imem_req);
      end
   endtask

   task automatic test_alu();
      do_fetch(16'h1042, 0);
      checks++;
      if (en !== 1'b1 || alu_sel !== 4'h1 || sela !== 6'd1
          || selb !== 6'd2) begin
         errors++;
         $display("FAIL alu_dec: got en=%b s=%h a=%0d b=%0d exp 1/1/1/2",
                  en, alu_sel, sela, selb);
      end
      step();
      alu_out   = 8'h09;
      alu_flags = 3'b000;
      checks++;
      if (en !== 1'b1 || we !== 1'b0 || alu_sel !== 4'h1
          || sela !== 6'd1 || selb !== 6'd2) begin
         errors++;
         $display("FAIL alu_exec: got en=%b we=%b s=%h a=%0d b=%0d",
                  en, we, alu_sel, sela, selb);
      end
      step();
      alu_out = 8'h55;
      #1;
      checks++;
      if (we !== 1'b1 || write !== 8'h09 || sela !== 6'd1) begin
         errors++;
         $display("FAIL alu_wb: got we=%b w=%h a=%0d exp 1/09/1",
                  we, write, sela);
      end
      step();
      checks++;
      if (we !== 1'b0 || pc !== 8'h02) begin
         errors++;
         $display("FAIL alu_post: got we=%b pc=%h exp 0/02", we, pc);
      end
   endtask

   task automatic test_branch();
      do_reset();
      run_alu(16'h1042, 8'h00, 3'b001);
      do_fetch(16'hA045, 0);
      step();
      step();
      checks++;
      if (pc !== 8'h02) begin
         errors++;
         $display("FAIL bz_setup: got %h exp 02", pc);
      end
      do_fetch(16'hB03C, 0);
      checks++;
      if (en !== 1'b0 || we !== 1'b0 || pc !== 8'h02) begin
         errors++;
         $display("FAIL bz_dec: got en=%b we=%b pc=%h exp 0/0/02",
                  en, we, pc);
      end
      step();
      checks++;
      if (pc !== 8'hFE || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL bz_taken: got pc=%h req=%b exp FE/1", pc, imem_req);
      end
      do_reset();
      run_alu(16'h1042, 8'h00, 3'b000);
      do_fetch(16'hD000, 0);
      step();
      checks++;
      if (pc !== 8'h02) begin
         errors++;
         $display("FAIL nop_pc: got %h exp 02", pc);
      end
      do_fetch(16'hB03C, 0);
      step();
      checks++;
      if (pc !== 8'h03) begin
         errors++;
         $display("FAIL bz_not: got %h exp 03", pc);
      end
   endtask

   task automatic test_jmp();
      do_reset();
      do_fetch(16'hC03F, 0);
      step();
      checks++;
      if (pc !== 8'hFF) begin
         errors++;
         $display("FAIL jmp_back: got %h exp FF", pc);
      end
      do_fetch(16'hC001, 0);
      step();
      checks++;
      if (pc !== 8'h00 || imem_addr !== 8'h00) begin
         errors++;
         $display("FAIL jmp_wrap: got %h/%h exp 00/00", pc, imem_addr);
      end
   endtask

   task automatic test_halt();
      do_fetch(16'hF000, 0);
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_dec: got %b exp 0", halted);
      end
      step();
      for (int i = 0; i < 20; i++) begin
         imem_data  = 16'hA045;
         imem_valid = i[0];
         checks++;
         if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 8'h00
             || en !== 1'b0 || we !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold%0d: got h=%b req=%b pc=%h en=%b we=%b",
                     i, halted, imem_req, pc, en, we);
         end
         step();
      end
      imem_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      do_fetch(16'h1042, 0);
      step();
      checks++;
      if (en !== 1'b1 || halted !== 1'b0) begin
         errors++;
         $display("FAIL mid_exec: got en=%b h=%b exp 1/0", en, halted);
      end
      rst        = 1'b1;
      imem_valid = 1'b1;
      imem_data  = 16'hA045;
      step();
      checks++;
      if (we !== 1'b0 || pc !== 8'h00 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst: got we=%b pc=%h req=%b exp 0/00/0",
                  we, pc, imem_req);
      end
      rst        = 1'b0;
      imem_valid = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00 || we !== 1'b0) begin
         errors++;
         $display("FAIL mid_restart: got req=%b addr=%h we=%b exp 1/00/0",
                  imem_req, imem_addr, we);
      end
      rst        = 1'b1;
      imem_valid = 1'b1;
      step();
      rst        = 1'b0;
      imem_valid = 1'b0;
      step();
      checks++;
      if (imem_req !== 1'b1 || en !== 1'b0 || sela !== 6'd0) begin
         errors++;
         $display("FAIL rst_valid_drop: got req=%b en=%b a=%0d exp 1/0/0",
                  imem_req, en, sela);
      end
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_alu();
      test_branch();
      test_jmp();
      test_halt();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
